clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measuring counterpart to the team's clock divider.
- Samples a slow, divided or PLL-derived square wave on sig_in in the clock_in domain and measures two values in clock_in cycles: the period (rise to rise) and the high time (rise to fall).
- Recovers the divisor and duty cycle on-chip, so PLL and divider outputs can be checked without an external counter.
- Sits between the divider/PLL outputs and the status/readout logic.

Parameters:
- WIDTH, 16: width of the period and high-time counters and outputs.
- SYNC_STAGES, 2: number of flops in the sig_in synchronizer; must be ≥ 2.

Ports:
- clock_in  input  1  measurement clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal being measured; asynchronous to clock_in.
- enable  input  1  measurement enable, level-sensitive.
- period_out  output  WIDTH  last measured period, in clock_in cycles.
- high_out  output  WIDTH  last measured high time, in clock_in cycles.
- valid  output  1  one-cycle pulse when period_out/high_out update.
- stall  output  1  sticky; no rising edge seen for 2^WIDTH-1 cycles.

Behaviour:
- Reset (asynchronous, active-low):
  - Clears the synchronizer, the edge-history flop, the counter, high_reg, period_out, high_out, valid and stall to 0.
  - State goes to IDLE.
  - Reset mid-measurement discards the partial count.
- Synchronizer and edge detection:
  - sig_in passes through SYNC_STAGES flops; s is the last stage and s_d is s delayed by one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- States:
  - IDLE: counter held at 0; valid = 0; outputs keep their last values. enable=1 -> ARM.
  - ARM: waits for rise. On rise, cnt <= 1 and go to MEAS. No valid is produced, because the first partial period is discarded.
  - MEAS: cnt <= cnt + 1 each cycle.
    - On fall: high_reg <= cnt.
    - On rise: period_out <= cnt, high_out <= high_reg, valid <= 1, stall <= 0, cnt <= 1; stay in MEAS.
- Counter semantics: for rises at detection cycles t0 and t0+N, period_out = N. For a fall at t0+H, high_out = H.
- Timeout:
  - If cnt reaches 2^WIDTH-1 in MEAS with no rise, set stall <= 1 and go to ARM.
  - period_out/high_out are not updated, and cnt does not wrap.
  - stall clears only on the next valid, or on reset.
- enable deasserted in any state: go to IDLE next cycle and abandon the measurement in progress; no valid is issued. stall holds its value.
- Simultaneous events:
  - rise and timeout in the same cycle: rise wins (valid, no stall).
  - rise and enable=0 in the same cycle: enable wins (no valid).
- Latency:
  - valid rises SYNC_STAGES clock_in edges after the edge that first samples sig_in high, for the second and later rises.
  - period_out and high_out are valid in the same cycle as valid.
- Input constraint: sig_in high and low phases must each last ≥ 1 clock_in period. The minimum measurable period is 2 (high_out = 1). Shorter pulses may be missed; no detection of missed pulses is required.
- Width rules: all arithmetic is unsigned WIDTH-bit. high_out < period_out always holds for a legal input.

Test Plan:
- Case 1, divide-by-10: sig_in from a divide-by-10 source in the clock_in domain (5 cycles high, 5 low), enable=1.
  - No valid for the first rise.
  - Thereafter valid every 10 cycles with period_out = 10 and high_out = 5.
- Case 2, odd ratio: divide-by-7 source with 3 cycles high and 4 low -> period_out = 7, high_out = 3 on every valid.
- Case 3, minimum period: sig_in toggling every cycle -> period_out = 2, high_out = 1, valid every 2 cycles.
- Case 4, timeout: WIDTH = 4, sig_in held low after one rise.
  - stall = 1 exactly 15 cycles after the counter started, and state returns to ARM.
  - Then resume a period-6 input -> stall clears with the first valid (period_out = 6).
- Case 5, enable drop: drop enable mid-period for 3 cycles, then reassert.
  - No valid during the gap.
  - The first post-enable rise only arms.
  - The next valid carries the correct period; outputs are unchanged during the gap.
- Case 6, reset mid-measurement: assert reset_n = 0 asynchronously (between clock edges) mid-period.
  - All outputs go to 0 immediately.
  - After release with enable = 1, the first valid appears only after two rises.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of a slow
// asynchronous square wave, counted in clock_in cycles.
module clock_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_high;
    logic [WIDTH-1:0]       r_period;
    logic [WIDTH-1:0]       r_high_out;
    logic                   r_valid;
    logic                   r_stall;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic [WIDTH-1:0]       w_cnt_nxt;
    logic [WIDTH-1:0]       w_high_nxt;
    logic [WIDTH-1:0]       w_period_nxt;
    logic [WIDTH-1:0]       w_high_out_nxt;
    logic                   w_valid_nxt;
    logic                   w_stall_nxt;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // Priority: enable low beats everything; in MEAS a rise beats the timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_high_nxt     = r_high;
        w_period_nxt   = r_period;
        w_high_out_nxt = r_high_out;
        w_valid_nxt    = 1'b0;
        w_stall_nxt    = r_stall;

        if (!enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ARM;
                end
                ARM: begin
                    w_cnt_nxt = '0;
                    if (w_rise) begin
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = MEAS;
                    end
                end
                MEAS: begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (w_fall) begin
                        w_high_nxt = r_cnt;
                    end
                    if (w_rise) begin
                        w_period_nxt   = r_cnt;
                        w_high_out_nxt = r_high;
                        w_valid_nxt    = 1'b1;
                        w_stall_nxt    = 1'b0;
                        w_cnt_nxt      = CNT_ONE;
                    end else if (r_cnt == CNT_MAX) begin
                        // Saturated without a rise: flag it and re-arm rather than wrap.
                        w_stall_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ARM;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sync     <= '0;
            r_s_d      <= 1'b0;
            r_cnt      <= '0;
            r_high     <= '0;
            r_period   <= '0;
            r_high_out <= '0;
            r_valid    <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d      <= w_s;
            r_cnt      <= w_cnt_nxt;
            r_high     <= w_high_nxt;
            r_period   <= w_period_nxt;
            r_high_out <= w_high_out_nxt;
            r_valid    <= w_valid_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high_out;
    assign valid      = r_valid;
    assign stall      = r_stall;

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: a 16-bit instance for the main
// cases and a 4-bit instance for the timeout case.
module tb_clock_period_meter;

    typedef struct {
        int per;
        int hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig;
    logic        en;
    logic [15:0] period_out;
    logic [15:0] high_out;
    logic        valid;
    logic        stall;

    logic        sig4;
    logic        en4;
    logic [3:0]  period4;
    logic [3:0]  high4;
    logic        valid4;
    logic        stall4;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_vld_cyc = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    clock_period_meter #(.WIDTH(16), .SYNC_STAGES(2)) u_dut (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .sig_in     (sig),
        .enable     (en),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .stall      (stall)
    );

    clock_period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clock_in   (clk),
        .reset_n    (rst_n),
        .sig_in     (sig4),
        .enable     (en4),
        .period_out (period4),
        .high_out   (high4),
        .valid      (valid4),
        .stall      (stall4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n periods of h high / l low; every rise after an arming rise
    // expects a result.
    task automatic gen_periods(input int h, input int l, input int n, input bit first_arms);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (i > 0 || !first_arms) begin
                e.per = h + l;
                e.hi  = h;
                sb_q.push_back(e);
            end
            sig = 1'b1;
            repeat (h) tick();
            sig = 1'b0;
            repeat (l) tick();
        end
    endtask

    task automatic start_case();
        last_vld_cyc = -1;
        sig = 1'b0;
        en  = 1'b1;
        repeat (3) tick();
    endtask

    task automatic end_case(input string tag);
        repeat (8) tick();
        check_eq(tag, sb_q.size(), 0);
        en = 1'b0;
        repeat (3) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("period_out", period_out, e.per);
                check_eq("high_out", high_out, e.hi);
                check_eq("stall_on_valid", stall, 0);
                if (last_vld_cyc >= 0) check_eq("valid_interval", cyc - last_vld_cyc, e.per);
                last_vld_cyc = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   nv;
        int   first_i;
        rst_n = 1'b0;
        sig   = 1'b0;
        en    = 1'b0;
        sig4  = 1'b0;
        en4   = 1'b0;
        #12;
        check_eq("rst_period", period_out, 0);
        check_eq("rst_high", high_out, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_stall4", stall4, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Divide-by-10, 50% duty
        start_case();
        gen_periods(5, 5, 6, 1'b1);
        end_case("div10_drain");

        // Divide-by-7, 3 high / 4 low
        start_case();
        gen_periods(3, 4, 6, 1'b1);
        end_case("div7_drain");

        // Minimum period
        start_case();
        gen_periods(1, 1, 8, 1'b1);
        end_case("min_drain");

        // Timeout on the 4-bit instance
        en4 = 1'b1;
        repeat (3) tick();
        sig4 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 3) sig4 = 1'b0;
        end
        check_eq("stall4_before", stall4, 0);
        check_eq("valid4_before", valid4, 0);
        tick();
        check_eq("stall4_set", stall4, 1);
        check_eq("period4_kept", period4, 0);
        check_eq("high4_kept", high4, 0);
        nv = 0;
        first_i = -1;
        for (int i = 0; i < 30; i++) begin
            if (valid4) begin
                nv++;
                if (nv == 1) begin
                    first_i = i;
                    check_eq("period4_resume", period4, 6);
                    check_eq("high4_resume", high4, 3);
                    check_eq("stall4_cleared", stall4, 0);
                end
            end else if (nv == 0 && (i == 0 || i == 8)) begin
                check_eq("stall4_held", stall4, 1);
            end
            sig4 = (i < 18) && ((i % 6) < 3);
            tick();
        end
        check_eq("valid4_first_at", first_i, 9);
        check_eq("valid4_count", nv, 2);
        en4 = 1'b0;
        tick();

        // Enable dropped for 3 cycles in the low phase
        start_case();
        gen_periods(5, 5, 3, 1'b1);
        e.per = 10;
        e.hi  = 5;
        sb_q.push_back(e);
        sig = 1'b1;
        repeat (5) tick();
        sig = 1'b0;
        tick();
        en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            check_eq("gap_valid", valid, 0);
            check_eq("gap_period", period_out, 10);
            check_eq("gap_high", high_out, 5);
        end
        en = 1'b1;
        last_vld_cyc = -1;
        tick();
        gen_periods(5, 5, 2, 1'b1);
        end_case("endrop_drain");

        // Asynchronous reset in the low phase
        start_case();
        gen_periods(5, 5, 4, 1'b1);
        repeat (3) tick();
        check_eq("pre_rst_period", period_out, 10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_period", period_out, 0);
        check_eq("arst_high", high_out, 0);
        check_eq("arst_valid", valid, 0);
        check_eq("arst_stall", stall, 0);
        check_eq("arst_sb", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        last_vld_cyc = -1;
        repeat (2) tick();
        check_eq("post_rst_period", period_out, 0);
        gen_periods(5, 5, 3, 1'b1);
        end_case("rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
